// File: rtl/red_pitaya_pfd_scheduler.sv
// Time-shares one pipelined CORDIC phase engine between NCH IQ requesters.
// A round-robin arbiter picks one IQ pair per cycle. The pair is registered
// to the engine, and its {valid, channel} tag rides a shift register that
// matches the engine latency. When a tag exits, the returned phase is
// unwrapped for its channel with a saturating turn counter.
module red_pitaya_pfd_scheduler #(
    parameter int NCH        = 4,
    parameter int INPUTWIDTH = 12,
    parameter int PHASEWIDTH = 12,
    parameter int TURNWIDTH  = 2,
    parameter int SIGNALBITS = 14,
    parameter int CORDIC_LAT = 10
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic [NCH-1:0]                 req_i,
    input  logic [NCH*INPUTWIDTH-1:0]      i_i,
    input  logic [NCH*INPUTWIDTH-1:0]      q_i,
    input  logic [NCH-1:0]                 clear_i,
    output logic [NCH-1:0]                 gnt_o,
    output logic [INPUTWIDTH-1:0]          cordic_i_o,
    output logic [INPUTWIDTH-1:0]          cordic_q_o,
    input  logic [PHASEWIDTH-1:0]          cordic_ph_i,
    output logic                           res_valid_o,
    output logic [$clog2(NCH)-1:0]         res_ch_o,
    output logic [SIGNALBITS-1:0]          res_o,
    output logic [NCH*SIGNALBITS-1:0]      integral_o
);

    localparam int CW = $clog2(NCH);
    localparam logic [TURNWIDTH-1:0] TURN_MAX = {1'b0, {(TURNWIDTH-1){1'b1}}};
    localparam logic [TURNWIDTH-1:0] TURN_MIN = {1'b1, {(TURNWIDTH-1){1'b0}}};

    logic [CW-1:0]         ptr;
    logic [CW-1:0]         gsel;
    logic [CW-1:0]         scan_idx;
    int                    scan_sum;
    logic                  xfer;

    logic                  issue_v;
    logic [CW-1:0]         issue_ch;
    logic [CORDIC_LAT-1:0] tag_v;
    logic [CW-1:0]         tag_ch [CORDIC_LAT];

    logic [TURNWIDTH-1:0]  turns  [NCH];
    logic [1:0]            last_q [NCH];

    logic                  ex_v;
    logic [CW-1:0]         ex_ch;
    logic [1:0]            ph_q;
    logic [TURNWIDTH-1:0]  cur_t;
    logic [1:0]            cur_lq;
    logic [TURNWIDTH-1:0]  new_t;

    // Cyclic priority search starting at the round-robin pointer
    always_comb begin
        gnt_o    = '0;
        gsel     = '0;
        xfer     = 1'b0;
        scan_sum = 0;
        scan_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            scan_sum = int'(ptr) + k;
            if (scan_sum >= NCH) scan_sum = scan_sum - NCH;
            scan_idx = CW'(scan_sum);
            if (!xfer && req_i[scan_idx]) begin
                gnt_o[scan_idx] = 1'b1;
                gsel            = scan_idx;
                xfer            = 1'b1;
            end
        end
    end

    // Pointer moves just past the granted channel; held when nothing transfers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (gsel == CW'(NCH - 1)) ? '0 : gsel + 1'b1;
        end
    end

    // Register the granted sample to the engine and launch its tag
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cordic_i_o <= '0;
            cordic_q_o <= '0;
            issue_v    <= 1'b0;
            issue_ch   <= '0;
        end else begin
            issue_v  <= xfer;
            issue_ch <= gsel;
            if (xfer) begin
                cordic_i_o <= i_i[gsel*INPUTWIDTH +: INPUTWIDTH];
                cordic_q_o <= q_i[gsel*INPUTWIDTH +: INPUTWIDTH];
            end
        end
    end

    // Tag delay line, aligned so the tag exits together with its engine phase
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tag_v <= '0;
            for (int k = 0; k < CORDIC_LAT; k++) tag_ch[k] <= '0;
        end else begin
            tag_v[0]  <= issue_v;
            tag_ch[0] <= issue_ch;
            for (int k = 1; k < CORDIC_LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_ch[k] <= tag_ch[k-1];
            end
        end
    end

    assign ex_v  = tag_v[CORDIC_LAT-1];
    assign ex_ch = tag_ch[CORDIC_LAT-1];
    assign ph_q  = cordic_ph_i[PHASEWIDTH-1 -: 2];

    // Quadrant-crossing detection with saturation; a clear overrides the count
    always_comb begin
        cur_t  = turns[ex_ch];
        cur_lq = last_q[ex_ch];
        new_t  = cur_t;
        if (clear_i[ex_ch]) begin
            new_t = '0;
        end else if (cur_lq == 2'b11 && ph_q == 2'b00 && cur_t != TURN_MAX) begin
            new_t = cur_t + 1'b1;
        end else if (cur_lq == 2'b00 && ph_q == 2'b11 && cur_t != TURN_MIN) begin
            new_t = cur_t - 1'b1;
        end
    end

    // Per-channel unwrap state, held integrals and the result strobe
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < NCH; c++) begin
                turns[c]  <= '0;
                last_q[c] <= 2'b11;
            end
            integral_o  <= '0;
            res_valid_o <= 1'b0;
            res_ch_o    <= '0;
            res_o       <= '0;
        end else begin
            res_valid_o <= ex_v;
            if (ex_v) begin
                res_ch_o <= ex_ch;
                res_o    <= {new_t, cordic_ph_i};
            end
            for (int c = 0; c < NCH; c++) begin
                if (ex_v && ex_ch == CW'(c)) begin
                    turns[c]  <= new_t;
                    last_q[c] <= clear_i[c] ? 2'b11 : ph_q;
                    integral_o[c*SIGNALBITS +: SIGNALBITS] <= {new_t, cordic_ph_i};
                end else if (clear_i[c]) begin
                    turns[c]  <= '0;
                    last_q[c] <= 2'b11;
                    integral_o[c*SIGNALBITS+PHASEWIDTH +: TURNWIDTH] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_red_pitaya_pfd_scheduler.sv
// Bench for red_pitaya_pfd_scheduler. The engine stand-in returns the q
// sample as the phase, delayed by the engine latency. A negedge monitor
// models the arbiter and the unwrap, and scoreboards every result.
module tb_red_pitaya_pfd_scheduler;

    localparam int NCH = 4;
    localparam int IW  = 12;
    localparam int PW  = 12;
    localparam int TW  = 2;
    localparam int SB  = 14;
    localparam int LAT = 10;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic [NCH-1:0]    req = '0;
    logic [NCH-1:0]    clear = '0;
    logic [NCH*IW-1:0] i_in = '0;
    logic [NCH*IW-1:0] q_in = '0;
    logic [NCH-1:0]    gnt;
    logic [IW-1:0]     cordic_i;
    logic [IW-1:0]     cordic_q;
    logic [PW-1:0]     ph;
    logic              res_valid;
    logic [1:0]        res_ch;
    logic [SB-1:0]     res;
    logic [NCH*SB-1:0] integral;

    int errors = 0;
    int checks = 0;

    red_pitaya_pfd_scheduler #(
        .NCH(NCH), .INPUTWIDTH(IW), .PHASEWIDTH(PW),
        .TURNWIDTH(TW), .SIGNALBITS(SB), .CORDIC_LAT(LAT)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .req_i(req), .i_i(i_in), .q_i(q_in),
        .clear_i(clear), .gnt_o(gnt), .cordic_i_o(cordic_i), .cordic_q_o(cordic_q),
        .cordic_ph_i(ph), .res_valid_o(res_valid), .res_ch_o(res_ch),
        .res_o(res), .integral_o(integral)
    );

    always #5 clk = ~clk;

    // Engine stand-in: phase = q sample, LAT cycles after it is presented
    logic [PW-1:0] eng [LAT];
    always @(posedge clk) begin
        eng[0] <= cordic_q;
        for (int k = 1; k < LAT; k++) eng[k] <= eng[k-1];
    end
    assign ph = eng[LAT-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int            ch;
        logic [PW-1:0] ph;
        int            cyc;
    } exp_t;
    exp_t sbq[$];

    int              cyc = 0;
    int              m_ptr;
    int              m_turn [NCH];
    logic [1:0]      m_lq [NCH];
    logic [NCH*SB-1:0] m_int;
    logic [NCH-1:0]  clr_prev;
    logic [IW-1:0]   last_i;
    logic [IW-1:0]   last_q;

    // Monitor: reference arbiter, scoreboard and unwrap model
    always @(negedge clk) begin
        exp_t          e;
        int            c, nt, gi, handled, s;
        logic [1:0]    q2;
        logic [SB-1:0] exp_res;
        logic [NCH-1:0] exp_g;
        cyc++;
        if (!rstn) begin
            sbq.delete();
            m_ptr = 0;
            for (int k = 0; k < NCH; k++) begin
                m_turn[k] = 0;
                m_lq[k]   = 2'b11;
            end
            m_int    = '0;
            clr_prev = '0;
            last_i   = '0;
            last_q   = '0;
            chk("rst_res_valid", res_valid, 0);
            chk("rst_integral", integral, 0);
            chk("rst_cordic_q", cordic_q, 0);
        end else begin
            chk("cordic_i", cordic_i, last_i);
            chk("cordic_q", cordic_q, last_q);
            chk("spurious_result", (res_valid && sbq.size() == 0), 0);
            handled = -1;
            if (res_valid && sbq.size() > 0) begin
                e  = sbq.pop_front();
                c  = e.ch;
                q2 = e.ph[PW-1 -: 2];
                nt = m_turn[c];
                if (clr_prev[c]) nt = 0;
                else if (m_lq[c] == 2'b11 && q2 == 2'b00 && nt < 1) nt = nt + 1;
                else if (m_lq[c] == 2'b00 && q2 == 2'b11 && nt > -2) nt = nt - 1;
                exp_res = {TW'(nt), e.ph};
                chk("res_ch", res_ch, c);
                chk("res_o", res, exp_res);
                chk("latency", cyc - e.cyc, LAT + 2);
                m_turn[c] = nt;
                m_lq[c]   = clr_prev[c] ? 2'b11 : q2;
                m_int[c*SB +: SB] = exp_res;
                handled = c;
            end
            for (int k = 0; k < NCH; k++) begin
                if (clr_prev[k] && k != handled) begin
                    m_turn[k] = 0;
                    m_lq[k]   = 2'b11;
                    m_int[k*SB+PW +: TW] = '0;
                end
            end
            chk("integral", integral, m_int);
            exp_g = '0;
            gi    = -1;
            for (int k = 0; k < NCH; k++) begin
                s = (m_ptr + k) % NCH;
                if (gi < 0 && req[s]) begin
                    gi       = s;
                    exp_g[s] = 1'b1;
                end
            end
            chk("gnt", gnt, exp_g);
            if (gi >= 0) begin
                sbq.push_back('{gi, q_in[gi*IW +: PW], cyc});
                last_i = i_in[gi*IW +: IW];
                last_q = q_in[gi*IW +: IW];
                m_ptr  = (gi + 1) % NCH;
            end
            clr_prev = clear;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    // One transfer from channel c carrying phase code p
    task automatic send(input int c, input logic [IW-1:0] p);
        i_in[c*IW +: IW] = IW'(300 + c);
        q_in[c*IW +: IW] = p;
        req = '0;
        req[c] = 1'b1;
        step();
        req = '0;
    endtask

    logic [IW-1:0] up_seq [4];
    logic [IW-1:0] dn_seq [4];

    initial begin
        up_seq = '{12'h100, 12'h600, 12'hA00, 12'hF00};
        dn_seq = '{12'hA00, 12'h600, 12'h100, 12'hF00};
        #1 rstn = 1'b0;
        wait_cycles(3);
        rstn = 1'b1;
        step();

        // All channels requesting: grants rotate 0,1,2,3,0,1,2,3
        for (int c = 0; c < NCH; c++) begin
            i_in[c*IW +: IW] = IW'(100 * (c + 1));
            q_in[c*IW +: IW] = IW'(c * 12'h400 + 12'h080);
        end
        req = '1;
        for (int k = 0; k < 8; k++) begin
            #1 chk("rr_order", gnt, 64'(1) << (k % NCH));
            step();
        end
        req = '0;
        wait_cycles(14);

        // Single request on ch2 (last quadrant 10, phase 0: no wrap)
        i_in[2*IW +: IW] = 12'd1000;
        q_in[2*IW +: IW] = 12'd0;
        req = 4'b0100;
        #1 chk("gnt_ch2", gnt, 4'b0100);
        step();
        req = '0;
        wait_cycles(10);
        #1 chk("ch2_not_yet", res_valid, 0);
        step();
        #1 chk("ch2_valid", res_valid, 1);
        chk("ch2_ch", res_ch, 2);
        chk("ch2_res", res, 14'h0000);
        wait_cycles(3);

        // ch0: +wrap then -wrap
        clear = 4'b0001;
        step();
        clear = '0;
        send(0, 12'hF00);
        send(0, 12'h100);
        wait_cycles(14);
        chk("ch0_up", integral[0 +: SB], 14'h1100);
        send(0, 12'hF00);
        wait_cycles(14);
        chk("ch0_down", integral[0 +: SB], 14'h0F00);

        // ch1: saturation at both ends of the 2-bit turn counter
        clear = 4'b0010;
        step();
        clear = '0;
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < 4; k++) send(1, up_seq[k]);
        wait_cycles(14);
        chk("ch1_sat_hi", integral[SB +: SB], 14'h1F00);
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < 4; k++) send(1, dn_seq[k]);
        wait_cycles(14);
        chk("ch1_sat_lo", integral[SB +: SB], 14'h2F00);

        // ch3: clear landing on the same cycle as a ch3 result
        clear = 4'b1000;
        step();
        clear = '0;
        send(3, 12'h100);
        wait_cycles(14);
        chk("ch3_pre", integral[3*SB +: SB], 14'h1100);
        send(3, 12'h600);
        wait_cycles(10);
        clear = 4'b1000;
        step();
        clear = '0;
        #1 chk("clr_res_valid", res_valid, 1);
        chk("clr_res", res, 14'h0600);
        chk("clr_integral", integral[3*SB +: SB], 14'h0600);
        send(3, 12'h600);
        wait_cycles(14);
        chk("ch3_after", integral[3*SB +: SB], 14'h0600);

        // Reset pulse with five tags in flight
        for (int c = 0; c < NCH; c++) q_in[c*IW +: IW] = IW'(12'h0C0 + c * 12'h100);
        req = '1;
        wait_cycles(5);
        req = '0;
        step();
        rstn = 1'b0;
        #1 chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_integral", integral, 0);
        step();
        rstn = 1'b1;
        wait_cycles(17);
        req = '1;
        #1 chk("ptr_after_rst", gnt, 4'b0001);
        step();
        req = '0;
        wait_cycles(14);
        chk("sb_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
